// File: rtl/sap_cu_var.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sap_cu_var : SAP control unit, one-hot T-states, variable-length cycles.   |
// | Optional feature macro: SAP_CU_SINGLE_STEP_EN (adds the step input).       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module sap_cu_var #(
  parameter int T_W   = 6,
  parameter int OPC_W = 4,
  parameter logic [OPC_W-1:0] OP_LDA = OPC_W'(0),
  parameter logic [OPC_W-1:0] OP_ADD = OPC_W'(1),
  parameter logic [OPC_W-1:0] OP_SUB = OPC_W'(2),
  parameter logic [OPC_W-1:0] OP_STA = OPC_W'(4),
  parameter logic [OPC_W-1:0] OP_LDI = OPC_W'(5),
  parameter logic [OPC_W-1:0] OP_JMP = OPC_W'(6),
  parameter logic [OPC_W-1:0] OP_JC  = OPC_W'(7),
  parameter logic [OPC_W-1:0] OP_JZ  = OPC_W'(8),
  parameter logic [OPC_W-1:0] OP_OUT = OPC_W'(14),
  parameter logic [OPC_W-1:0] OP_HLT = OPC_W'(15)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             run,
`ifdef SAP_CU_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  output logic             Cp,
  output logic             Ep,
  output logic             Lp,
  output logic             Ea,
  output logic             Su,
  output logic             Eu,
  output logic             nLm,
  output logic             nCE,
  output logic             nLi,
  output logic             nEi,
  output logic             nLa,
  output logic             nLb,
  output logic             nLo,
  output logic             nWE,
  output logic             nHLT,
  output logic [T_W-1:0]   state
);

  localparam logic [T_W-1:0] C_T1 = T_W'(1);

  typedef enum logic [3:0] {
    I_LDA, I_ADD, I_SUB, I_STA, I_LDI, I_JMP, I_JC, I_JZ, I_OUT, I_HLT, I_UND
  } instr_e;

  instr_e         instr;
  logic           halt;
  logic           adv;
  logic           active;
  logic           set_halt;
  logic           we_n;
  logic [T_W-1:0] next_state;
  logic           t1, t2, t3, t4, t5, t6;

  assign t1 = state[0];
  assign t2 = state[1];
  assign t3 = state[2];
  assign t4 = state[3];
  assign t5 = state[4];
  assign t6 = state[5];

`ifdef SAP_CU_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Priority chain: when two opcode parameters collide the earlier one wins.
  always_comb begin
    if      (opcode == OP_LDA) instr = I_LDA;
    else if (opcode == OP_ADD) instr = I_ADD;
    else if (opcode == OP_SUB) instr = I_SUB;
    else if (opcode == OP_STA) instr = I_STA;
    else if (opcode == OP_LDI) instr = I_LDI;
    else if (opcode == OP_JMP) instr = I_JMP;
    else if (opcode == OP_JC)  instr = I_JC;
    else if (opcode == OP_JZ)  instr = I_JZ;
    else if (opcode == OP_OUT) instr = I_OUT;
    else if (opcode == OP_HLT) instr = I_HLT;
    else                       instr = I_UND;
  end

  always_comb begin
    next_state = {state[T_W-2:0], 1'b0};
    set_halt   = 1'b0;
    if (t1 || t2 || t3) begin
      next_state = {state[T_W-2:0], 1'b0};
    end else if (t4) begin
      case (instr)
        I_LDA, I_ADD, I_SUB, I_STA: next_state = {state[T_W-2:0], 1'b0};
        I_HLT: begin
          next_state = state;
          set_halt   = 1'b1;
        end
        default: next_state = C_T1;
      endcase
    end else if (t5) begin
      if (instr != I_ADD && instr != I_SUB) next_state = C_T1;
    end else begin
      next_state = C_T1;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= C_T1;
      halt  <= 1'b0;
    end else if (!run) begin
      state <= C_T1;
    end else if (!halt && adv) begin
      state <= next_state;
      if (set_halt) halt <= 1'b1;
    end
  end

  assign active = run && !halt && !CLR;
  assign nHLT   = ~halt;
  assign nWE    = run ? we_n : 1'bz;

  // Opcode and flags only reach the outputs from T4 onward, so opcode
  // changes during fetch cannot glitch any control.
  always_comb begin
    Cp = 1'b0; Ep = 1'b0; Lp = 1'b0; Ea = 1'b0; Su = 1'b0; Eu = 1'b0;
    nLm = 1'b1; nCE = 1'b1; nLi = 1'b1; nEi = 1'b1;
    nLa = 1'b1; nLb = 1'b1; nLo = 1'b1; we_n = 1'b1;
    if (active) begin
      if (t1) begin
        Ep  = 1'b1;
        nLm = 1'b0;
      end else if (t2) begin
        Cp = 1'b1;
      end else if (t3) begin
        nCE = 1'b0;
        nLi = 1'b0;
      end else if (t4) begin
        case (instr)
          I_LDA, I_ADD, I_SUB, I_STA: begin
            nEi = 1'b0;
            nLm = 1'b0;
          end
          I_LDI: begin
            nEi = 1'b0;
            nLa = 1'b0;
          end
          I_JMP: begin
            nEi = 1'b0;
            Lp  = 1'b1;
          end
          I_JC: begin
            nEi = 1'b0;
            Lp  = flag_c;
          end
          I_JZ: begin
            nEi = 1'b0;
            Lp  = flag_z;
          end
          I_OUT: begin
            Ea  = 1'b1;
            nLo = 1'b0;
          end
          default: ;
        endcase
      end else if (t5) begin
        case (instr)
          I_LDA: begin
            nCE = 1'b0;
            nLa = 1'b0;
          end
          I_ADD, I_SUB: begin
            nCE = 1'b0;
            nLb = 1'b0;
          end
          I_STA: begin
            Ea   = 1'b1;
            we_n = 1'b0;
          end
          default: ;
        endcase
      end else if (t6) begin
        if (instr == I_ADD || instr == I_SUB) begin
          Eu  = 1'b1;
          Su  = (instr == I_SUB);
          nLa = 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sap_cu_var.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_sap_cu_var : directed self-checking bench for sap_cu_var.              |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_sap_cu_var;

  // Control vector order: {Cp,Ep,Lp,Ea,Su,Eu, nLm,nCE,nLi,nEi,nLa,nLb,nLo, nWE}
  localparam logic [13:0] C_IDLE = 14'b000000_1111111_1;
  localparam logic [13:0] C_T1   = 14'b010000_0111111_1;
  localparam logic [13:0] C_T2   = 14'b100000_1111111_1;
  localparam logic [13:0] C_T3   = 14'b000000_1001111_1;
  localparam logic [13:0] C_ADR  = 14'b000000_0110111_1;
  localparam logic [13:0] C_LDA5 = 14'b000000_1011011_1;
  localparam logic [13:0] C_ADD5 = 14'b000000_1011101_1;
  localparam logic [13:0] C_ADD6 = 14'b000001_1111011_1;
  localparam logic [13:0] C_SUB6 = 14'b000011_1111011_1;
  localparam logic [13:0] C_STA5 = 14'b000100_1111111_0;
  localparam logic [13:0] C_LDI4 = 14'b000000_1110011_1;
  localparam logic [13:0] C_JP4  = 14'b001000_1110111_1;
  localparam logic [13:0] C_JN4  = 14'b000000_1110111_1;
  localparam logic [13:0] C_OUT4 = 14'b000100_1111110_1;

  logic       CLK, CLR, run, flag_c, flag_z;
  logic [3:0] opcode;
  logic       Cp, Ep, Lp, Ea, Su, Eu;
  logic       nLm, nCE, nLi, nEi, nLa, nLb, nLo, nHLT;
  wire        nWE;
  logic [5:0] state;
  wire [13:0] ctl = {Cp, Ep, Lp, Ea, Su, Eu, nLm, nCE, nLi, nEi, nLa, nLb, nLo, nWE};

  int n_checks = 0;
  int n_fail   = 0;

  sap_cu_var dut (
    .CLK(CLK), .CLR(CLR), .run(run), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .Cp(Cp), .Ep(Ep), .Lp(Lp), .Ea(Ea), .Su(Su), .Eu(Eu),
    .nLm(nLm), .nCE(nCE), .nLi(nLi), .nEi(nEi), .nLa(nLa), .nLb(nLb), .nLo(nLo),
    .nWE(nWE), .nHLT(nHLT), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    #2;
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (state !== 6'b000001) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", state, 6'b000001);
    end
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE);
    end
    n_checks++;
    if (nHLT !== 1'b1) begin
      n_fail++; $display("FAIL reset_nhlt: got %b want 1", nHLT);
    end
    CLR = 1'b0;
    tick();
    n_checks++;
    if (state !== 6'b000010) begin
      n_fail++; $display("FAIL reset_first_edge: got %b want %b", state, 6'b000010);
    end
    do_reset();
  endtask

  task automatic test_lda_add_sub();
    logic [3:0]  op [17] = '{0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2};
    logic [5:0]  es [17] = '{1,2,4,8,16, 1,2,4,8,16,32, 1,2,4,8,16,32};
    logic [13:0] ec [17] = '{C_T1,C_T2,C_T3,C_ADR,C_LDA5,
                             C_T1,C_T2,C_T3,C_ADR,C_ADD5,C_ADD6,
                             C_T1,C_T2,C_T3,C_ADR,C_ADD5,C_SUB6};
    for (int i = 0; i < 17; i++) begin
      opcode = op[i];
      #1;
      n_checks++;
      if (state !== es[i]) begin
        n_fail++; $display("FAIL arith_state[%0d]: got %b want %b", i, state, es[i]);
      end
      n_checks++;
      if (ctl !== ec[i]) begin
        n_fail++; $display("FAIL arith_ctl[%0d]: got %b want %b", i, ctl, ec[i]);
      end
      tick();
    end
    n_checks++;
    if (state !== 6'b000001) begin
      n_fail++; $display("FAIL arith_end: got %b want %b", state, 6'b000001);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op [17] = '{4,4,4,4,4, 5,5,5,5, 14,14,14,14, 3,3,3,3};
    logic [5:0]  es [17] = '{1,2,4,8,16, 1,2,4,8, 1,2,4,8, 1,2,4,8};
    logic [13:0] ec [17] = '{C_T1,C_T2,C_T3,C_ADR,C_STA5,
                             C_T1,C_T2,C_T3,C_LDI4,
                             C_T1,C_T2,C_T3,C_OUT4,
                             C_T1,C_T2,C_T3,C_IDLE};
    for (int i = 0; i < 17; i++) begin
      opcode = op[i];
      #1;
      n_checks++;
      if (state !== es[i]) begin
        n_fail++; $display("FAIL b2b_state[%0d]: got %b want %b", i, state, es[i]);
      end
      n_checks++;
      if (ctl !== ec[i]) begin
        n_fail++; $display("FAIL b2b_ctl[%0d]: got %b want %b", i, ctl, ec[i]);
      end
      tick();
    end
    n_checks++;
    if (state !== 6'b000001) begin
      n_fail++; $display("FAIL b2b_end: got %b want %b", state, 6'b000001);
    end
  endtask

  task automatic test_cond_jumps();
    logic [3:0]  op [8] = '{8,8,8,8, 7,7,7,7};
    logic [5:0]  es [8] = '{1,2,4,8, 1,2,4,8};
    logic [13:0] ec [8] = '{C_T1,C_T2,C_T3,C_JP4, C_T1,C_T2,C_T3,C_JN4};
    flag_z = 1'b1;
    flag_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      opcode = op[i];
      #1;
      n_checks++;
      if (state !== es[i]) begin
        n_fail++; $display("FAIL jump_state[%0d]: got %b want %b", i, state, es[i]);
      end
      n_checks++;
      if (ctl !== ec[i]) begin
        n_fail++; $display("FAIL jump_ctl[%0d]: got %b want %b", i, ctl, ec[i]);
      end
      tick();
    end
    n_checks++;
    if (state !== 6'b000001) begin
      n_fail++; $display("FAIL jump_end: got %b want %b", state, 6'b000001);
    end
    flag_z = 1'b0;
  endtask

  task automatic test_halt();
    opcode = 4'd15;
    tick(); tick(); tick();
    n_checks++;
    if (state !== 6'b001000 || ctl !== C_IDLE || nHLT !== 1'b1) begin
      n_fail++; $display("FAIL halt_t4: got state %b ctl %b nHLT %b want 001000 %b 1",
                         state, ctl, nHLT, C_IDLE);
    end
    tick();
    n_checks++;
    if (nHLT !== 1'b0) begin
      n_fail++; $display("FAIL halt_set: got nHLT %b want 0", nHLT);
    end
    opcode = 4'd0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (state !== 6'b001000 || ctl !== C_IDLE) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got state %b ctl %b want 001000 %b",
                           i, state, ctl, C_IDLE);
      end
      tick();
    end
    do_reset();
    n_checks++;
    if (nHLT !== 1'b1 || state !== 6'b000001) begin
      n_fail++; $display("FAIL halt_clear: got nHLT %b state %b want 1 000001", nHLT, state);
    end
    tick();
    n_checks++;
    if (state !== 6'b000010) begin
      n_fail++; $display("FAIL halt_resume: got %b want 000010", state);
    end
    do_reset();
  endtask

  task automatic test_clr_mid();
    opcode = 4'd1;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (state !== 6'b010000) begin
      n_fail++; $display("FAIL clr_pre: got %b want 010000", state);
    end
    CLR = 1'b1;
    #1;
    n_checks++;
    if (state !== 6'b000001 || ctl !== C_IDLE || nHLT !== 1'b1) begin
      n_fail++; $display("FAIL clr_async: got state %b ctl %b nHLT %b want 000001 %b 1",
                         state, ctl, nHLT, C_IDLE);
    end
    CLR = 1'b0;
    tick();
    n_checks++;
    if (state !== 6'b000010) begin
      n_fail++; $display("FAIL clr_next: got %b want 000010", state);
    end
    do_reset();
  endtask

  task automatic test_program_mode();
    opcode = 4'd6;
    tick(); tick(); tick();
    n_checks++;
    if (state !== 6'b001000 || ctl !== C_JP4) begin
      n_fail++; $display("FAIL prog_jmp_t4: got state %b ctl %b want 001000 %b",
                         state, ctl, C_JP4);
    end
    run = 1'b0;
    #1;
    n_checks++;
    if (ctl[13:1] !== C_IDLE[13:1] || Lp !== 1'b0) begin
      n_fail++; $display("FAIL prog_inactive: got %b want %b", ctl[13:1], C_IDLE[13:1]);
    end
    tick();
    n_checks++;
    if (state !== 6'b000001) begin
      n_fail++; $display("FAIL prog_t1: got %b want 000001", state);
    end
    tick();
    n_checks++;
    if (state !== 6'b000001) begin
      n_fail++; $display("FAIL prog_hold_t1: got %b want 000001", state);
    end
    run = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_T1) begin
      n_fail++; $display("FAIL prog_restart_ctl: got %b want %b", ctl, C_T1);
    end
    tick();
    n_checks++;
    if (state !== 6'b000010) begin
      n_fail++; $display("FAIL prog_restart_state: got %b want 000010", state);
    end
    do_reset();
  endtask

  initial begin
    CLK = 1'b0; CLR = 1'b1; run = 1'b1; opcode = 4'd0;
    flag_c = 1'b0; flag_z = 1'b0;
    #12;
    test_reset();
    test_lda_add_sub();
    test_back_to_back();
    test_cond_jumps();
    test_halt();
    test_clr_mid();
    test_program_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
